// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side and ALU-side signals shared by the arbiter.
interface alu_arbiter_if;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic [3:0] s0, s1;
  logic       done0, done1;
  logic [7:0] res_f, res_ff;
  logic [5:0] res_flags;
  logic       busy, gnt_id;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_s;
  logic [7:0] alu_f, alu_ff;
  logic       alu_equal, alu_gt, alu_lt, alu_zero, alu_carry, alu_ovf;

  // arbiter side
  modport slave (
    input  req0, req1, a0, b0, a1, b1, s0, s1,
    input  alu_f, alu_ff, alu_equal, alu_gt, alu_lt, alu_zero, alu_carry, alu_ovf,
    output done0, done1, res_f, res_ff, res_flags, busy, gnt_id,
    output alu_a, alu_b, alu_s
  );

  // requesters plus ALU side
  modport master (
    output req0, req1, a0, b0, a1, b1, s0, s1,
    output alu_f, alu_ff, alu_equal, alu_gt, alu_lt, alu_zero, alu_carry, alu_ovf,
    input  done0, done1, res_f, res_ff, res_flags, busy, gnt_id,
    input  alu_a, alu_b, alu_s
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a shared 8-bit ALU.
// Grants one port, drives registered operands, waits ALU_LAT edges,
// captures results/flags and pulses the owner's done for one cycle.
module alu_arbiter #(
  parameter int ALU_LAT = 1  // 0..4, 0 = combinational ALU
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       last;
  logic       pick;

  // Winner for this IDLE cycle: a lone requester wins, a tie goes to the
  // port that did not win last time.
  always_comb begin
    pick = bus.req1;
    if (bus.req0 && bus.req1) pick = ~last;
  end

  // Sequencer FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 3'd0;
      last          <= 1'b1;
      bus.alu_a     <= 8'h00;
      bus.alu_b     <= 8'h00;
      bus.alu_s     <= 4'h0;
      bus.res_f     <= 8'h00;
      bus.res_ff    <= 8'h00;
      bus.res_flags <= 6'h00;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.gnt_id    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            bus.alu_a  <= pick ? bus.a1 : bus.a0;
            bus.alu_b  <= pick ? bus.b1 : bus.b0;
            bus.alu_s  <= pick ? bus.s1 : bus.s0;
            bus.gnt_id <= pick;
            last       <= pick;
            cnt        <= 3'(ALU_LAT);
            bus.busy   <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            // ALU outputs are valid now; capture and flag completion
            bus.res_f     <= bus.alu_f;
            bus.res_ff    <= bus.alu_ff;
            bus.res_flags <= {bus.alu_ovf, bus.alu_carry, bus.alu_zero,
                              bus.alu_lt, bus.alu_gt, bus.alu_equal};
            bus.done0     <= ~bus.gnt_id;
            bus.done1     <= bus.gnt_id;
            state         <= S_DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_DONE: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU_LAT=1 and ALU_LAT=3 instances, each
// fronting a stub ALU (F=A+B, FF=A^B, flags from A and B).
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus_l1 ();
  alu_arbiter_if bus_l3 ();

  alu_arbiter #(.ALU_LAT(1)) u_l1 (.clk(clk), .rst(rst), .bus(bus_l1.slave));
  alu_arbiter #(.ALU_LAT(3)) u_l3 (.clk(clk), .rst(rst), .bus(bus_l3.slave));

  // Stub ALU result: {F, FF, ovf, carry, zero, lt, gt, eq}
  function automatic logic [21:0] alu_stub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    logic       ovf;
    sum = {1'b0, a} + {1'b0, b};
    ovf = (a[7] == b[7]) && (sum[7] != a[7]);
    return {sum[7:0], a ^ b, ovf, sum[8], sum[7:0] == 8'h00, a < b, a > b, a == b};
  endfunction

  logic [21:0] p1;
  logic [21:0] p3 [3];

  // Stub ALU pipelines: 1 edge and 3 edges of latency
  always @(posedge clk) begin
    p1    <= alu_stub(bus_l1.alu_a, bus_l1.alu_b);
    p3[0] <= alu_stub(bus_l3.alu_a, bus_l3.alu_b);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign {bus_l1.alu_f, bus_l1.alu_ff, bus_l1.alu_ovf, bus_l1.alu_carry, bus_l1.alu_zero,
          bus_l1.alu_lt, bus_l1.alu_gt, bus_l1.alu_equal} = p1;
  assign {bus_l3.alu_f, bus_l3.alu_ff, bus_l3.alu_ovf, bus_l3.alu_carry, bus_l3.alu_zero,
          bus_l3.alu_lt, bus_l3.alu_gt, bus_l3.alu_equal} = p3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All registered outputs of the ALU_LAT=1 instance packed together
  function automatic logic [31:0] outs_l1();
    return {bus_l1.alu_a, bus_l1.alu_b, bus_l1.alu_s, bus_l1.res_f[7:0] | bus_l1.res_ff,
            bus_l1.res_flags[1:0] | bus_l1.res_flags[5:4] | bus_l1.res_flags[3:2],
            bus_l1.done0, bus_l1.done1, bus_l1.busy, bus_l1.gnt_id};
  endfunction

  function automatic logic [31:0] outs_l3();
    return {bus_l3.alu_a, bus_l3.alu_b, bus_l3.alu_s, bus_l3.res_f[7:0] | bus_l3.res_ff,
            bus_l3.res_flags[1:0] | bus_l3.res_flags[5:4] | bus_l3.res_flags[3:2],
            bus_l3.done0, bus_l3.done1, bus_l3.busy, bus_l3.gnt_id};
  endfunction

  typedef struct {
    logic       port;
    logic [7:0] a, b;
    logic [3:0] s;
    logic [7:0] f, ff;
    logic [5:0] flags;
  } vec_t;

  vec_t vecs [6];

  task automatic set_req(input logic port, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] s);
    if (port) begin
      bus_l1.req1 = v; bus_l1.a1 = a; bus_l1.b1 = b; bus_l1.s1 = s;
    end else begin
      bus_l1.req0 = v; bus_l1.a0 = a; bus_l1.b0 = b; bus_l1.s0 = s;
    end
  endtask

  // One request on the ALU_LAT=1 instance, checked against a vector
  task automatic run_vec(input vec_t v);
    int   lat;
    logic dn, other;
    lat = 99;
    @(negedge clk);
    set_req(v.port, 1'b1, v.a, v.b, v.s);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        check("grant_ops", {bus_l1.alu_a, bus_l1.alu_b, bus_l1.alu_s, bus_l1.busy},
              {v.a, v.b, v.s, 1'b1});
      end
      dn    = v.port ? bus_l1.done1 : bus_l1.done0;
      other = v.port ? bus_l1.done0 : bus_l1.done1;
      if (other) check("other_done", 32'(other), 32'd0);
      if (dn) begin
        lat = n;
        check("res_f", 32'(bus_l1.res_f), 32'(v.f));
        check("res_ff", 32'(bus_l1.res_ff), 32'(v.ff));
        check("res_flags", 32'(bus_l1.res_flags), 32'(v.flags));
        check("gnt_id", {bus_l1.gnt_id, bus_l1.busy}, {v.port, 1'b1});
        set_req(v.port, 1'b0, v.a, v.b, v.s);
        break;
      end
    end
    check("vec_latency", 32'(lat), 32'd3);
    if (lat == 99) set_req(v.port, 1'b0, v.a, v.b, v.s);
    @(posedge clk); #1;
    check("idle_hold", {bus_l1.busy, bus_l1.alu_a, bus_l1.alu_s}, {1'b0, v.a, v.s});
  endtask

  // Both ports request together on the ALU_LAT=1 instance
  task automatic run_pair(output int t0, output int t1);
    t0 = 99; t1 = 99;
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'h01, 8'h02, 4'h3);
    set_req(1'b1, 1'b1, 8'h10, 8'h20, 4'h5);
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (bus_l1.done0) begin
        t0 = n;
        check("pair_res0", 32'(bus_l1.res_f), 32'h03);
        set_req(1'b0, 1'b0, 8'h01, 8'h02, 4'h3);
      end
      if (bus_l1.done1) begin
        t1 = n;
        check("pair_res1", 32'(bus_l1.res_f), 32'h30);
        set_req(1'b1, 1'b0, 8'h10, 8'h20, 4'h5);
      end
      if (t0 != 99 && t1 != 99) break;
    end
    set_req(1'b0, 1'b0, 8'h01, 8'h02, 4'h3);
    set_req(1'b1, 1'b0, 8'h10, 8'h20, 4'h5);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, t1, lat, k;
    int dt[3];

    vecs[0] = '{1'b0, 8'h0F, 8'h05, 4'b0001, 8'h14, 8'h0A, 6'b000010};
    vecs[1] = '{1'b1, 8'hFF, 8'h01, 4'b0010, 8'h00, 8'hFE, 6'b011010};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 4'b0100, 8'h80, 8'h7E, 6'b100010};
    vecs[3] = '{1'b1, 8'h33, 8'h33, 4'b1000, 8'h66, 8'h00, 6'b000001};
    vecs[4] = '{1'b0, 8'h10, 8'h80, 4'b1111, 8'h90, 8'h90, 6'b000100};
    vecs[5] = '{1'b1, 8'h80, 8'h80, 4'b0110, 8'h00, 8'h00, 6'b111001};

    rst = 1'b1;
    bus_l1.req0 = 1'b0; bus_l1.req1 = 1'b0;
    bus_l1.a0 = 8'h0; bus_l1.b0 = 8'h0; bus_l1.s0 = 4'h0;
    bus_l1.a1 = 8'h0; bus_l1.b1 = 8'h0; bus_l1.s1 = 4'h0;
    bus_l3.req0 = 1'b0; bus_l3.req1 = 1'b0;
    bus_l3.a0 = 8'h0; bus_l3.b0 = 8'h0; bus_l3.s0 = 4'h0;
    bus_l3.a1 = 8'h0; bus_l3.b1 = 8'h0; bus_l3.s1 = 4'h0;

    // Reset held 2 cycles with REQ0 high: everything 0, then DONE0 at R+3
    set_req(1'b0, 1'b1, 8'h0F, 8'h05, 4'b0001);
    @(posedge clk); #1;
    check("reset_outs_1", outs_l1(), 32'd0);
    @(posedge clk); #1;
    check("reset_outs_2", outs_l1(), 32'd0);
    check("reset_outs_l3", outs_l3(), 32'd0);
    rst = 1'b0;
    lat = 99;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (bus_l1.done0) begin
        lat = n;
        check("reset_res_f", 32'(bus_l1.res_f), 32'h14);
        set_req(1'b0, 1'b0, 8'h0F, 8'h05, 4'b0001);
        break;
      end
    end
    set_req(1'b0, 1'b0, 8'h0F, 8'h05, 4'b0001);
    check("reset_release_latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    // Table of single requests, alternating ports
    foreach (vecs[i]) run_vec(vecs[i]);

    // Tie: last winner was port 1, so port 0 first, then port 1; repeat
    run_pair(t0, t1);
    check("tie1_done0", 32'(t0), 32'd3);
    check("tie1_done1", 32'(t1), 32'd7);
    run_pair(t0, t1);
    check("tie2_done0", 32'(t0), 32'd3);
    check("tie2_done1", 32'(t1), 32'd7);

    // Back-to-back on port 0: REQ0 held through three completions
    k = 0; dt = '{99, 99, 99};
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'h21, 8'h12, 4'h9);
    for (int n = 1; n <= 16 && k < 3; n++) begin
      @(posedge clk); #1;
      if (bus_l1.busy && bus_l1.gnt_id) check("b2b_gnt_id", 32'(bus_l1.gnt_id), 32'd0);
      if (bus_l1.done1) check("b2b_done1", 32'(bus_l1.done1), 32'd0);
      if (bus_l1.done0) begin
        dt[k] = n;
        k++;
        if (k == 3) set_req(1'b0, 1'b0, 8'h21, 8'h12, 4'h9);
      end
    end
    set_req(1'b0, 1'b0, 8'h21, 8'h12, 4'h9);
    check("b2b_done_a", 32'(dt[0]), 32'd3);
    check("b2b_done_b", 32'(dt[1]), 32'd7);
    check("b2b_done_c", 32'(dt[2]), 32'd11);
    @(posedge clk); #1;

    // Reset for one cycle during WAIT discards the operation
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'h44, 8'h11, 4'h2);
    @(posedge clk); #1;
    check("midrst_busy", 32'(bus_l1.busy), 32'd1);
    rst = 1'b1;
    set_req(1'b0, 1'b0, 8'h44, 8'h11, 4'h2);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_outs", outs_l1(), 32'd0);
    k = 0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      if (bus_l1.done0 || bus_l1.done1 || bus_l1.busy) k++;
    end
    check("midrst_no_done", 32'(k), 32'd0);
    lat = 99;
    @(negedge clk);
    set_req(1'b1, 1'b1, 8'h05, 8'h06, 4'h1);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (bus_l1.done1) begin
        lat = n;
        check("midrst_res_f", 32'(bus_l1.res_f), 32'h0B);
        break;
      end
    end
    set_req(1'b1, 1'b0, 8'h05, 8'h06, 4'h1);
    check("midrst_req1_latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    // ALU_LAT=3: REQ0 at T -> DONE0 at T+5; REQ1 at T+2 -> DONE1 at T+11
    t0 = 99; t1 = 99;
    @(negedge clk);
    bus_l3.req0 = 1'b1; bus_l3.a0 = 8'h01; bus_l3.b0 = 8'h02; bus_l3.s0 = 4'h7;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin
        bus_l3.req1 = 1'b1; bus_l3.a1 = 8'h20; bus_l3.b1 = 8'h03; bus_l3.s1 = 4'hA;
      end
      if (bus_l3.done0) begin
        t0 = n;
        check("l3_res0", 32'(bus_l3.res_f), 32'h03);
        bus_l3.req0 = 1'b0;
      end
      if (bus_l3.done1) begin
        t1 = n;
        check("l3_res1", {bus_l3.res_f, bus_l3.alu_s}, {8'h23, 4'hA});
        bus_l3.req1 = 1'b0;
        break;
      end
    end
    bus_l3.req0 = 1'b0; bus_l3.req1 = 1'b0;
    check("l3_done0", 32'(t0), 32'd5);
    check("l3_done1", 32'(t1), 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
